// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: speed selector constants
// and the binary-to-Gray mapping used to build the registered Gray output.
package gray_pkg;

    localparam int GRAY_SERIAL = 0;
    localparam int GRAY_MEDIUM = 1;
    localparam int GRAY_FAST   = 2;
    localparam int GRAY_MAX_W  = 32;

    // Callers zero-extend narrower words; the top bit then maps to itself.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/PrefixXor.sv
// Inclusive prefix XOR: PO[i] = PI[0] ^ ... ^ PI[i], with the network
// topology (serial, Brent-Kung, Sklansky) chosen by speed.
module PrefixXor
    import gray_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = GRAY_SERIAL
) (
    input  logic [width-1:0] PI,
    output logic [width-1:0] PO
);

    // Combinational prefix network; each level only reads nodes it does not write.
    always_comb begin
        logic [width-1:0] p;
        p = PI;
        case (speed)
            GRAY_MEDIUM: begin
                for (int l = 0; l < 5; l++) begin
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (2 << l)) == 0) begin
                            p[i] = p[i] ^ p[i - (1 << l)];
                        end else begin
                            p[i] = p[i];
                        end
                    end
                end
                for (int l = 4; l >= 0; l--) begin
                    for (int i = 0; i < width; i++) begin
                        if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (1 << l))) begin
                            p[i] = p[i] ^ p[i - (1 << l)];
                        end else begin
                            p[i] = p[i];
                        end
                    end
                end
            end
            GRAY_FAST: begin
                for (int l = 0; l < 5; l++) begin
                    for (int i = 0; i < width; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            p[i] = p[i] ^ p[((i >> l) << l) - 1];
                        end else begin
                            p[i] = p[i];
                        end
                    end
                end
            end
            default: begin
                for (int i = 1; i < width; i++) begin
                    p[i] = p[i] ^ p[i-1];
                end
            end
        endcase
        PO = p;
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding binary state, with registered binary and Gray
// outputs plus a one-cycle wrap pulse; Gray load goes through PrefixXor.
module gray_counter
    import gray_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = GRAY_SERIAL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [width-1:0] ld_gray_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [width-1:0] gray_o,
    output logic [width-1:0] bin_o,
    output logic             wrap_o
);

    localparam logic [width-1:0] ZERO     = {width{1'b0}};
    localparam logic [width-1:0] ALL_ONES = {width{1'b1}};
    localparam logic [width-1:0] ONE      = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] ld_rev_s;
    logic [width-1:0] ld_pref_s;
    logic [width-1:0] ld_bin_s;
    logic [width-1:0] b_q, b_d;
    logic [width-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Reverse the load word so the prefix accumulates from the MSB down.
    always_comb begin
        ld_rev_s = ZERO;
        ld_bin_s = ZERO;
        for (int i = 0; i < width; i++) begin
            ld_rev_s[i]           = ld_gray_i[width-1-i];
            ld_bin_s[width-1-i]   = ld_pref_s[i];
        end
    end

    PrefixXor #(
        .width (width),
        .speed (speed)
    ) u_g2b (
        .PI (ld_rev_s),
        .PO (ld_pref_s)
    );

    // Next-state: clear over load over count over hold.
    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            b_d    = ZERO;
            wrap_d = 1'b0;
        end else if (load_i) begin
            b_d    = ld_bin_s;
            wrap_d = 1'b0;
        end else if (en_i) begin
            if (!down_i) begin
                b_d    = b_q + ONE;
                wrap_d = (b_q == ALL_ONES);
            end else begin
                b_d    = b_q - ONE;
                wrap_d = (b_q == ZERO);
            end
        end else begin
            b_d    = b_q;
            wrap_d = 1'b0;
        end
        gray_d = width'(bin2gray(GRAY_MAX_W'(b_d)));
    end

    // Gray is registered from the next binary value so gray_o is a bare flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_q    <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_o  = b_q;
    assign gray_o = gray_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter at width 4: three instances (one per speed) against
// an arithmetic reference model, plus hand-computed directed expectations.
module tb_gray_counter;

    localparam int W    = 4;
    localparam int MODN = 1 << W;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr   = 1'b0;
    logic         load  = 1'b0;
    logic         en    = 1'b0;
    logic         down  = 1'b0;
    logic [W-1:0] ld    = '0;

    logic [W-1:0] g_o [3];
    logic [W-1:0] b_o [3];
    logic         w_o [3];
    logic [W-1:0] prev_g [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    for (genvar sp = 0; sp < 3; sp++) begin : g_dut
        gray_counter #(.width(W), .speed(sp)) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .clr_i     (clr),
            .load_i    (load),
            .ld_gray_i (ld),
            .en_i      (en),
            .down_i    (down),
            .gray_o    (g_o[sp]),
            .bin_o     (b_o[sp]),
            .wrap_o    (w_o[sp])
        );
    end

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned g2b(input int unsigned gv);
        int unsigned r;
        r = 0;
        for (int k = 0; k < W; k++) r = r ^ (gv >> k);
        return r % MODN;
    endfunction

    // Reference model: plain modular arithmetic on an integer count.
    int unsigned m_b;
    bit          m_wrap;
    bit          m_counted;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b <= 0; m_wrap <= 1'b0; m_counted <= 1'b0;
        end else if (clr) begin
            m_b <= 0; m_wrap <= 1'b0; m_counted <= 1'b0;
        end else if (load) begin
            m_b <= g2b(ld); m_wrap <= 1'b0; m_counted <= 1'b0;
        end else if (en) begin
            m_counted <= 1'b1;
            if (!down) begin
                m_b <= (m_b + 1) % MODN; m_wrap <= (m_b == MODN - 1);
            end else begin
                m_b <= (m_b + MODN - 1) % MODN; m_wrap <= (m_b == 0);
            end
        end else begin
            m_wrap <= 1'b0; m_counted <= 1'b0;
        end
    end

    // Per-cycle compare of every instance against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("bin[s%0d]", k), 32'(b_o[k]), m_b);
                check($sformatf("gray[s%0d]", k), 32'(g_o[k]), m_b ^ (m_b >> 1));
                check($sformatf("wrap[s%0d]", k), 32'(w_o[k]), 32'(m_wrap));
                if (m_counted)
                    check($sformatf("hamming[s%0d]", k), $countones(g_o[k] ^ prev_g[k]), 1);
            end
        end
        for (int k = 0; k < 3; k++) prev_g[k] = g_o[k];
    end

    task automatic cyc(input logic c, input logic l, input logic e, input logic d, input logic [W-1:0] v);
        @(negedge clk);
        #1;
        clr = c; load = l; en = e; down = d; ld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [W-1:0] eb, input logic [W-1:0] eg, input logic ew);
        check({nm, ".bin"},  32'(b_o[0]), 32'(eb));
        check({nm, ".gray"}, 32'(g_o[0]), 32'(eg));
        check({nm, ".wrap"}, 32'(w_o[0]), 32'(ew));
    endtask

    logic [W-1:0] up_gray [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        lit("reset", 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            lit($sformatf("up%0d", i + 1), 4'(i + 1), up_gray[i], 1'b0);
        end

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
        lit("load1000", 4'b1111, 4'b1000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        lit("wrap_up", 4'b0000, 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        lit("wrap_up_end", 4'b0000, 4'b0000, 1'b0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        lit("wrap_dn", 4'b1111, 4'b1000, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        lit("dn_next", 4'b1110, 4'b1001, 1'b0);

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
        lit("clr_prio", 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b1010);
        lit("load_prio", 4'b1100, 4'b1010, 1'b0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        lit("pre_rst", 4'b0101, 4'b0111, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_rst.bin[s%0d]", k), 32'(b_o[k]), 32'd0);
            check($sformatf("async_rst.gray[s%0d]", k), 32'(g_o[k]), 32'd0);
            check($sformatf("async_rst.wrap[s%0d]", k), 32'(w_o[k]), 32'd0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1; en = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        lit("post_rst", 4'b0001, 4'b0001, 1'b0);

        for (int i = 0; i < MODN + 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'd0);

        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        @(negedge clk);
        #1 chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL have parameter width, default 8: counter word width; legal values are 2 to 32.
REQ-002 The module SHALL have parameter speed, default 0: performance selector (0 serial, 1 Brent-Kung, 2 Sklansky), passed to the load-path Gray-to-binary converter.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port clr_i, input, 1 bit: synchronous clear to zero.
REQ-006 The module SHALL have port load_i, input, 1 bit: synchronous load of ld_gray_i.
REQ-007 The module SHALL have port ld_gray_i, input, width bits: load value, Gray-coded.
REQ-008 The module SHALL have port en_i, input, 1 bit: count enable.
REQ-009 The module SHALL have port down_i, input, 1 bit: count direction (0 up, 1 down), sampled when en_i=1.
REQ-010 The module SHALL have port gray_o, output, width bits: registered Gray-coded count.
REQ-011 The module SHALL have port bin_o, output, width bits: registered binary count.
REQ-012 The module SHALL have port wrap_o, output, 1 bit: registered one-cycle pulse on modular wrap.

Function
REQ-013 Internal state SHALL be a binary register B; gray_o SHALL always equal B ^ (B >> 1).
REQ-014 gray_o SHALL be driven directly from flip-flops, with no combinational logic after the register, so it is glitch-free for clock-domain crossing.
REQ-015 Per-cycle priority SHALL be clr_i > load_i > en_i > hold.
REQ-016 clr_i=1: B <= 0, wrap_o <= 0.
REQ-017 load_i=1 (clr_i=0): B <= Gray-to-binary(ld_gray_i), wrap_o <= 0; the loaded value SHALL appear on the outputs one cycle after the load edge.
REQ-018 en_i=1, down_i=0: B <= B+1 modulo 2^width; wrap_o <= 1 only if B was all-ones.
REQ-019 en_i=1, down_i=1: B <= B-1 modulo 2^width; wrap_o <= 1 only if B was 0.
REQ-020 Idle (no clr, load or en): B holds, wrap_o <= 0.
REQ-021 Consecutive gray_o values produced by counting SHALL differ in exactly one bit, including across the wrap.
REQ-022 Count latency SHALL be one cycle from the enabling edge to the updated outputs; throughput SHALL be one step per cycle.
REQ-023 A direction change between cycles SHALL take effect immediately, with no dead cycle.
REQ-024 All arithmetic SHALL be unsigned at width bits; carries and borrows out of the MSB SHALL be discarded apart from setting wrap_o.

Reset
REQ-025 While rst_ni=0, B=0, gray_o=0, bin_o=0 and wrap_o=0 SHALL hold immediately and asynchronously, regardless of clk_i.
REQ-026 Reset asserted mid-count SHALL abort the step; after deassertion, counting SHALL resume from 0 on the first enabled edge.
REQ-027 Reset deassertion SHALL be treated as synchronized externally; the block SHALL add no reset synchronizer.

Structure
REQ-028 A shared package gray_pkg SHALL hold a bin2gray function and the constants GRAY_SERIAL=0, GRAY_MEDIUM=1 and GRAY_FAST=2 for speed.
REQ-029 The load-path Gray-to-binary conversion SHALL be a single instance of the existing PrefixXor block, with width and speed passed through and ld_gray_i reversed into its PI so the prefix runs from MSB to LSB.
REQ-030 No other sub-modules SHALL be used.

Verification (width=4)
REQ-031 Reset, then en_i=1, down_i=0 for 5 cycles -> gray_o = 0001, 0011, 0010, 0110, 0111 and bin_o = 1 through 5.
REQ-032 Load ld_gray_i=1000 (bin 1111), then en_i=1 up for 1 cycle -> bin_o = 0000, gray_o = 0000, wrap_o high for exactly that one cycle.
REQ-033 From B=0, en_i=1, down_i=1 for 1 cycle -> bin_o = 1111, gray_o = 1000, wrap_o=1; on the next cycle (still down) -> bin_o = 1110, gray_o = 1001, wrap_o=0.
REQ-034 clr_i=1, load_i=1 and en_i=1 in the same cycle with ld_gray_i=1010 -> outputs 0; load_i=1 and en_i=1 together with ld_gray_i=1010 -> bin_o = 1100, with no increment applied.
REQ-035 Count to bin_o=0101, then assert rst_ni=0 mid-cycle -> all outputs 0 before the next clock edge; after release, one enabled up-count -> bin_o = 0001.
REQ-036 Run 2^width+3 random up/down steps for each speed in 0, 1 and 2 -> every count-driven gray_o transition has Hamming distance 1, and bin_o matches a reference model.
